// File: rtl/frame_writer_if.sv
// ---------------------------------------------------------------------------
// frame_writer_if
// Bundles the frame writer's control, pixel stream and SDRAM write bus.
//   Control : frame_start, frame_flip -> writer; busy, done, overrun <- writer
//   Pixels  : pix_valid, pix_index -> writer; pix_ready <- writer
//   SDRAM   : reader_busy, sdram_Wait, sdram_ac -> writer;
//             sdram_wr, sdram_addr, sdram_wdata <- writer
// master = the frame writer, slave = renderer / controller side.
// ---------------------------------------------------------------------------
interface frame_writer_if;
  logic         frame_start;
  logic         frame_flip;
  logic         pix_valid;
  logic [7:0]   pix_index;
  logic         pix_ready;
  logic         reader_busy;
  logic         sdram_Wait;
  logic         sdram_wr;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_wdata;
  logic         sdram_ac;
  logic         busy;
  logic         done;
  logic         overrun;

  modport master (
    input  frame_start, frame_flip, pix_valid, pix_index,
           reader_busy, sdram_Wait, sdram_ac,
    output pix_ready, sdram_wr, sdram_addr, sdram_wdata,
           busy, done, overrun
  );

  modport slave (
    output frame_start, frame_flip, pix_valid, pix_index,
           reader_busy, sdram_Wait, sdram_ac,
    input  pix_ready, sdram_wr, sdram_addr, sdram_wdata,
           busy, done, overrun
  );
endinterface

// File: rtl/frame_writer.sv
// ---------------------------------------------------------------------------
// frame_writer
// Packs 8-bit palette-index pixels (16 per 128-bit word, pixel 0 in the LSBs)
// and writes them into the back framebuffer in SDRAM, yielding the controller
// to the scanline reader whenever it is busy.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high
//   bus    - frame_writer_if.master (pixel stream, SDRAM write bus, status)
// ---------------------------------------------------------------------------
module frame_writer #(
  parameter logic [21:0] ADDR1          = 22'h100000,
  parameter logic [21:0] ADDR2          = 22'h200000,
  parameter int          WORDS_PER_LINE = 40,
  parameter int          LINES          = 480
) (
  input  logic           clock,
  input  logic           reset,
  frame_writer_if.master bus
);

  localparam int TOTAL_WORDS = WORDS_PER_LINE * LINES;
  localparam int XW  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int YW  = $clog2(LINES + 1);
  localparam int WCW = $clog2(TOTAL_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         r_state;
  logic [21:0]    r_base;
  logic [3:0]     r_pack_cnt;
  logic [119:0]   r_pack;
  logic [127:0]   r_hold;
  logic           r_hold_valid;
  logic [WCW-1:0] r_words;
  logic [XW-1:0]  r_wr_x;
  logic [YW-1:0]  r_wr_y;
  logic           r_wr;
  logic [21:0]    r_addr;
  logic [127:0]   r_wdata;
  logic           r_overrun;

  logic           w_pix_ready;
  logic           w_take;
  logic           w_pack_done;
  logic           w_last_pix;
  logic           w_accept;
  logic           w_issue;
  logic [21:0]    w_addr;

  // The 16th pixel of a word can only be taken once the hold register is free;
  // this depends on registers only, never on sdram_ac.
  assign w_pix_ready = (r_state == S_RUN) && !((r_pack_cnt == 4'd15) && r_hold_valid);
  assign w_take      = bus.pix_valid && w_pix_ready;
  assign w_pack_done = w_take && (r_pack_cnt == 4'd15);
  assign w_last_pix  = w_pack_done && (r_words == WCW'(TOTAL_WORDS - 1));
  assign w_accept    = r_wr && bus.sdram_ac;
  // A request can only start from an idle bus, so an accepted write is always
  // followed by at least one cycle with sdram_wr low.
  assign w_issue     = !r_wr && r_hold_valid && !bus.sdram_Wait && !bus.reader_busy;
  assign w_addr      = r_base + 22'(r_wr_y) * 22'(WORDS_PER_LINE) + 22'(r_wr_x);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_pack_cnt   <= '0;
      r_hold_valid <= 1'b0;
      r_words      <= '0;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= bus.frame_start && (r_state == S_RUN || r_state == S_DRAIN);

      // Pack side: bytes 0..14 accumulate; byte 15 goes straight into hold.
      if (w_take) begin
        for (int k = 0; k < 15; k++) begin
          if (r_pack_cnt == 4'(k)) r_pack[k*8 +: 8] <= bus.pix_index;
        end
        r_pack_cnt <= r_pack_cnt + 4'd1;
        if (r_pack_cnt == 4'd15) r_words <= r_words + 1'b1;
      end

      // A freshly completed word takes priority over the clear on acceptance.
      if (w_pack_done) begin
        r_hold       <= {bus.pix_index, r_pack};
        r_hold_valid <= 1'b1;
      end else if (w_accept) begin
        r_hold_valid <= 1'b0;
      end

      // Write side: request stays frozen until the controller accepts it.
      if (w_accept) begin
        r_wr <= 1'b0;
        if (r_wr_x == XW'(WORDS_PER_LINE - 1)) begin
          r_wr_x <= '0;
          r_wr_y <= r_wr_y + 1'b1;
        end else begin
          r_wr_x <= r_wr_x + 1'b1;
        end
      end else if (w_issue) begin
        r_wr    <= 1'b1;
        r_addr  <= w_addr;
        r_wdata <= r_hold;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.frame_start) begin
            r_state      <= S_RUN;
            r_base       <= bus.frame_flip ? ADDR2 : ADDR1;
            r_pack_cnt   <= '0;
            r_hold_valid <= 1'b0;
            r_words      <= '0;
            r_wr_x       <= '0;
            r_wr_y       <= '0;
          end
        end
        S_RUN: begin
          if (w_last_pix) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Only the final word can be in hold here, so its acceptance ends the frame.
          if (w_accept) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready   = w_pix_ready;
  assign bus.sdram_wr    = r_wr;
  assign bus.sdram_addr  = r_addr;
  assign bus.sdram_wdata = r_wdata;
  assign bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_writer
// Bench for frame_writer with a reduced frame (40 words x 4 lines). The
// reference model keeps accepted pixels in a queue; every accepted SDRAM write
// must carry the next 16 queued pixels at base + (words written so far).
// ---------------------------------------------------------------------------
module tb_frame_writer;
  localparam logic [21:0] A1 = 22'h100000;
  localparam logic [21:0] A2 = 22'h200000;
  localparam int WPL = 40;
  localparam int LN  = 4;
  localparam int FRAME_WORDS = WPL * LN;
  localparam int FRAME_PIX   = FRAME_WORDS * 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  frame_writer_if bus();

  frame_writer #(.ADDR1(A1), .ADDR2(A2), .WORDS_PER_LINE(WPL), .LINES(LN)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0]   q_pix[$];
  logic [21:0]  base_exp;
  int           words_done, nwrites, pix_total;
  logic [21:0]  last_addr, prev_last_addr;
  logic [127:0] last_data;

  // stimulus knobs
  int valid_pct = 100, ac_mode = 2, ac_pct = 50, busy_pct = 0, to_feed = 0;
  bit seq_pix = 1'b0, force_busy = 1'b0, force_wait = 1'b0;

  // previous-cycle bus snapshot
  bit           p_wr = 1'b0, p_ac = 1'b0, p_rst = 1'b1;
  logic [21:0]  p_addr;
  logic [127:0] p_data;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.pix_valid = (to_feed > 0) && ($urandom_range(99) < valid_pct);
    bus.pix_index = seq_pix ? 8'(pix_total) : 8'($urandom);
    case (ac_mode)
      0:       bus.sdram_ac = ($urandom_range(99) < ac_pct);
      1:       bus.sdram_ac = bus.sdram_wr && p_wr;   // ack in the second cycle of a request
      default: bus.sdram_ac = 1'b0;
    endcase
    bus.reader_busy = force_busy || ($urandom_range(99) < busy_pct);
    bus.sdram_Wait  = force_wait;
  endtask

  task automatic check_write();
    logic [127:0] w;
    w = '0;
    if (q_pix.size() < 16) begin
      chk("write_pixels_available", 160'(q_pix.size()), 160'd16);
    end else begin
      for (int k = 0; k < 16; k++) w[k*8 +: 8] = q_pix.pop_front();
      chk("wr_data", 160'(bus.sdram_wdata), 160'(w));
    end
    chk("wr_addr", 160'(bus.sdram_addr), 160'(base_exp + 22'(words_done)));
    words_done++;
    nwrites++;
    prev_last_addr = last_addr;
    last_addr      = bus.sdram_addr;
    last_data      = bus.sdram_wdata;
  endtask

  // Evaluate the current cycle (inputs already driven), then step one edge.
  task automatic cyc();
    if (!reset && bus.pix_valid && bus.pix_ready) begin
      q_pix.push_back(bus.pix_index);
      pix_total++;
      to_feed--;
    end
    if (!reset && bus.sdram_wr && bus.sdram_ac) check_write();
    p_wr = bus.sdram_wr; p_ac = bus.sdram_ac; p_rst = reset;
    p_addr = bus.sdram_addr; p_data = bus.sdram_wdata;
    @(posedge clock); #1;
    if (!p_rst && p_wr && !p_ac)
      chk("wr_stable", {9'd0, bus.sdram_wr, bus.sdram_addr, bus.sdram_wdata}, {9'd0, 1'b1, p_addr, p_data});
    else if (!p_rst && p_wr && p_ac)
      chk("wr_gap", 160'(bus.sdram_wr), 160'd0);
  endtask

  task automatic model_clear();
    q_pix.delete();
    words_done = 0; nwrites = 0; pix_total = 0;
  endtask

  task automatic start_frame(input bit flip);
    to_feed = 0;
    drive();
    bus.frame_start = 1'b1;
    bus.frame_flip  = flip;
    cyc();
    bus.frame_start = 1'b0;
    model_clear();
    base_exp = flip ? A2 : A1;
    chk("start_busy", 160'(bus.busy), 160'd1);
  endtask

  task automatic feed(input int n, input int budget);
    int c = 0;
    to_feed = n;
    while (to_feed > 0 && c < budget) begin drive(); cyc(); c++; end
    chk("feed_complete", 160'(to_feed), 160'd0);
    to_feed = 0;
  endtask

  task automatic drain(input int target, input int budget);
    int c = 0;
    to_feed = 0;
    while (nwrites < target && c < budget) begin drive(); cyc(); c++; end
    chk("drain_writes", 160'(nwrites), 160'(target));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    to_feed = 0;
    repeat (n) begin drive(); cyc(); end
    reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    string name;
    bit rst, fs, flip, pv;
    bit e_busy, e_done, e_ovr, e_ready, e_wr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int acc0;
    logic [7:0] first_pix;
    bus.frame_start = 0; bus.frame_flip = 0; bus.pix_valid = 0; bus.pix_index = 0;
    bus.reader_busy = 0; bus.sdram_Wait = 0; bus.sdram_ac = 0;
    last_addr = '0; prev_last_addr = '0; last_data = '0; base_exp = A1;
    model_clear();

    // ---- control vectors: reset, idle, start, overrun ----
    vecs[0] = '{"reset",     1,0,0,0, 0,0,0,0,0};
    vecs[1] = '{"idle_pv",   0,0,0,1, 0,0,0,0,0};
    vecs[2] = '{"start",     0,1,0,0, 1,0,0,1,0};
    vecs[3] = '{"ovr_pulse", 0,1,1,0, 1,0,1,1,0};
    vecs[4] = '{"ovr_end",   0,0,0,0, 1,0,0,1,0};
    vecs[5] = '{"reset_run", 1,0,0,0, 0,0,0,0,0};
    vecs[6] = '{"idle_again",0,0,1,1, 0,0,0,0,0};
    for (int i = 0; i < 7; i++) begin
      drive();
      reset = vecs[i].rst; bus.frame_start = vecs[i].fs;
      bus.frame_flip = vecs[i].flip; bus.pix_valid = vecs[i].pv;
      cyc();
      chk({vecs[i].name, ".busy"},    160'(bus.busy),      160'(vecs[i].e_busy));
      chk({vecs[i].name, ".done"},    160'(bus.done),      160'(vecs[i].e_done));
      chk({vecs[i].name, ".overrun"}, 160'(bus.overrun),   160'(vecs[i].e_ovr));
      chk({vecs[i].name, ".ready"},   160'(bus.pix_ready), 160'(vecs[i].e_ready));
      chk({vecs[i].name, ".wr"},      160'(bus.sdram_wr),  160'(vecs[i].e_wr));
    end
    bus.frame_start = 0; reset = 0;
    chk("reset_addr",  160'(bus.sdram_addr),  160'd0);
    chk("reset_wdata", 160'(bus.sdram_wdata), 160'd0);

    // ---- one word, buffer 1 ----
    do_reset(2);
    start_frame(1'b0);
    seq_pix = 1; valid_pct = 100; ac_mode = 1; busy_pct = 0;
    feed(16, 100);
    drain(1, 100);
    repeat (10) begin drive(); cyc(); end
    chk("t1_nwrites", 160'(nwrites), 160'd1);
    chk("t1_addr", 160'(last_addr), 160'(22'h100000));
    chk("t1_data", 160'(last_data), 160'(128'h0F0E0D0C0B0A09080706050403020100));

    // ---- 656 pixels, buffer 2, with an overrun attempt in the middle ----
    do_reset(2);
    start_frame(1'b1);
    seq_pix = 1; valid_pct = 70; ac_mode = 1; busy_pct = 20;
    feed(100, 1000);
    drive(); bus.frame_start = 1'b1; bus.frame_flip = 1'b0; cyc(); bus.frame_start = 1'b0;
    chk("overrun_high", 160'(bus.overrun), 160'd1);
    drive(); cyc();
    chk("overrun_low", 160'(bus.overrun), 160'd0);
    feed(556, 3000);
    drain(41, 500);
    chk("t2_nwrites", 160'(nwrites), 160'd41);
    chk("t2_addr41", 160'(last_addr), 160'(22'h200028));
    chk("t2_addr40", 160'(prev_last_addr), 160'(22'h200027));
    chk("t2_data41", 160'(last_data), 160'(128'h8F8E8D8C8B8A89888786858483828180));

    // ---- controller stalls with sdram_ac low for 50 cycles ----
    seq_pix = 0; valid_pct = 100; ac_mode = 2; busy_pct = 0;
    acc0 = pix_total;
    to_feed = 1000;
    repeat (50) begin drive(); cyc(); end
    to_feed = 0;
    // one full word sits in hold; the packer then fills all but its final byte
    chk("stall_accepted", 160'(pix_total - acc0), 160'(16 + 15));
    chk("stall_ready", 160'(bus.pix_ready), 160'd0);
    chk("stall_wr", 160'(bus.sdram_wr), 160'd1);
    ac_mode = 0; ac_pct = 50;
    feed(1, 300);
    drain(43, 300);

    // ---- reader_busy / sdram_Wait gate a pending word ----
    ac_mode = 2; force_busy = 1;
    feed(16, 100);
    repeat (5) begin drive(); cyc(); chk("gate_busy_wr", 160'(bus.sdram_wr), 160'd0); end
    force_busy = 0; force_wait = 1;
    repeat (5) begin drive(); cyc(); chk("gate_wait_wr", 160'(bus.sdram_wr), 160'd0); end
    force_wait = 0;
    drive(); cyc();
    chk("gate_release_wr", 160'(bus.sdram_wr), 160'd1);
    force_busy = 1;
    repeat (3) begin drive(); cyc(); chk("busy_keeps_wr", 160'(bus.sdram_wr), 160'd1); end
    force_busy = 0; ac_mode = 1;
    drain(44, 100);

    // ---- rest of the frame with random throttling ----
    valid_pct = 80; ac_mode = 0; ac_pct = 60; busy_pct = 25;
    feed(FRAME_PIX - pix_total, 40000);
    drain(FRAME_WORDS, 5000);
    chk("frame_nwrites", 160'(nwrites), 160'(FRAME_WORDS));
    chk("frame_last_addr", 160'(last_addr), 160'(A2 + 22'(FRAME_WORDS - 1)));
    chk("frame_done", 160'(bus.done), 160'd1);
    chk("frame_busy", 160'(bus.busy), 160'd0);
    drive(); bus.pix_valid = 1'b1; cyc();
    chk("done_ready", 160'(bus.pix_ready), 160'd0);
    chk("done_no_extra_pix", 160'(q_pix.size()), 160'd0);

    // ---- reset during a pending request, then a clean restart ----
    busy_pct = 0; ac_mode = 2; valid_pct = 100;
    start_frame(1'b0);
    feed(16, 100);
    for (int c = 0; c < 10 && !bus.sdram_wr; c++) begin drive(); cyc(); end
    chk("pre_reset_wr", 160'(bus.sdram_wr), 160'd1);
    feed(5, 50);
    reset = 1'b1; drive(); cyc(); reset = 1'b0;
    chk("reset_drops_wr", 160'(bus.sdram_wr), 160'd0);
    chk("reset_drops_busy", 160'(bus.busy), 160'd0);
    start_frame(1'b0);
    ac_mode = 1;
    feed(16, 100);
    first_pix = q_pix[0];
    drain(1, 100);
    chk("restart_addr", 160'(last_addr), 160'(A1));
    chk("restart_byte0", 160'(last_data[7:0]), 160'(first_pix));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
